// File: rtl/pcf8563_time_sched.sv
// PCF8563 time-read scheduler: polls seconds..years and publishes BCD time.
// Optional seconds recheck after the frame: define PCF8563_SEC_RECHECK_EN.
module pcf8563_time_sched #(
  parameter int unsigned POLL_DIV    = 100_000_000,
  parameter logic [7:0]  BASE_ADDR   = 8'h02,
  parameter int unsigned N_REGS      = 7,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       force_rd,
  output logic       req_start,
  output logic [7:0] req_addr,
  input  logic [7:0] req_rdata,
  input  logic       req_done,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [5:0] hour,
  output logic [5:0] day,
  output logic [2:0] wday,
  output logic [4:0] mon,
  output logic       century,
  output logic [7:0] year,
  output logic       vl_flag,
  output logic       time_valid,
  output logic       busy,
  output logic       err_timeout
);

  localparam int PW = $clog2(POLL_DIV);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_PUB
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_nxt;
  logic [7:0]      w_addr_nxt;
  logic [PW-1:0]   r_poll;
  logic            r_pend;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_shadow [0:6];
  logic [7:0]      r_addr;
  logic            r_err;
  logic [6:0]      r_sec;
  logic [6:0]      r_min;
  logic [5:0]      r_hour;
  logic [5:0]      r_day;
  logic [2:0]      r_wday;
  logic [4:0]      r_mon;
  logic            r_cent;
  logic [7:0]      r_year;
  logic            r_vl;

  logic            w_tick;
  logic            w_take;
  logic            w_tmo;
  logic            w_last;
  logic            w_load;
  logic            w_unused;

`ifdef PCF8563_SEC_RECHECK_EN
  logic [7:0]      r_chk;
  logic            r_retried;
  logic            w_chk_idx;
  logic            w_retry;

  assign w_chk_idx = (r_idx == 3'(N_REGS));
  assign w_retry   = (r_chk[6:0] != r_shadow[0][6:0]) && !r_retried;
`endif

  assign w_tick = en && (r_poll == POLL_LAST);
  assign w_take = (r_state == S_IDLE) && en && r_pend;
  assign w_tmo  = (r_state == S_WAIT) && !req_done && (r_tmo == TMO_LAST);
  assign w_last = (r_idx == IDX_LAST);
  assign w_load = (r_state == S_NEXT) && (w_state_nxt == S_PUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = 3'd0;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (req_done) begin
          w_state_nxt = S_NEXT;
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_NEXT: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
`ifdef PCF8563_SEC_RECHECK_EN
        end else if (w_chk_idx) begin
          if (w_retry) begin
            w_state_nxt = S_ISSUE;
            w_idx_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_PUB;
          end
        end else if (w_last) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = 3'(N_REGS);
`else
        end else if (w_last) begin
          w_state_nxt = S_PUB;
`endif
        end else begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
      S_PUB: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_start  = (r_state == S_ISSUE);
    time_valid = (r_state == S_PUB);
    busy       = (r_state != S_IDLE);
  end

  // The recheck access re-reads the seconds register.
`ifdef PCF8563_SEC_RECHECK_EN
  assign w_addr_nxt = (w_idx_nxt == 3'(N_REGS)) ? BASE_ADDR
                    : BASE_ADDR + {5'd0, w_idx_nxt};
`else
  assign w_addr_nxt = BASE_ADDR + {5'd0, w_idx_nxt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll <= '0;
      r_pend <= 1'b0;
    end else if (!en) begin
      r_poll <= '0;
      r_pend <= 1'b0;
    end else begin
      r_poll <= w_tick ? '0 : r_poll + 1'b1;
      if (w_take) begin
        r_pend <= 1'b0;
      end else if (w_tick || force_rd) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 3'd0;
      r_addr <= 8'd0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        r_shadow[i] <= 8'd0;
      end
`ifdef PCF8563_SEC_RECHECK_EN
      r_chk     <= 8'd0;
      r_retried <= 1'b0;
`endif
    end else begin
      r_idx <= w_idx_nxt;
      if (w_state_nxt == S_ISSUE) begin
        r_addr <= w_addr_nxt;
      end
      if (r_state == S_ISSUE) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end else if (w_load) begin
        r_err <= 1'b0;
      end
`ifdef PCF8563_SEC_RECHECK_EN
      if (w_take) begin
        r_retried <= 1'b0;
      end else if (r_state == S_NEXT && en && w_chk_idx && w_retry) begin
        r_retried <= 1'b1;
      end
      if (r_state == S_WAIT && req_done) begin
        if (w_chk_idx) begin
          r_chk <= req_rdata;
        end else begin
          r_shadow[r_idx] <= req_rdata;
        end
      end
`else
      if (r_state == S_WAIT && req_done) begin
        r_shadow[r_idx] <= req_rdata;
      end
`endif
    end
  end

  // Fields load on entry to PUBLISH so they are valid with time_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec  <= '0;
      r_vl   <= 1'b0;
      r_min  <= '0;
      r_hour <= '0;
      r_day  <= '0;
      r_wday <= '0;
      r_mon  <= '0;
      r_cent <= 1'b0;
      r_year <= '0;
    end else if (w_load) begin
      r_sec  <= r_shadow[0][6:0];
      r_vl   <= r_shadow[0][7];
      r_min  <= r_shadow[1][6:0];
      r_hour <= r_shadow[2][5:0];
      r_day  <= r_shadow[3][5:0];
      r_wday <= r_shadow[4][2:0];
      r_mon  <= r_shadow[5][4:0];
      r_cent <= r_shadow[5][7];
      r_year <= r_shadow[6];
    end
  end

`ifdef PCF8563_SEC_RECHECK_EN
  assign w_unused = ^{r_shadow[1][7], r_shadow[2][7:6], r_shadow[3][7:6],
                      r_shadow[4][7:3], r_shadow[5][6:5], r_chk[7]};
`else
  assign w_unused = ^{r_shadow[1][7], r_shadow[2][7:6], r_shadow[3][7:6],
                      r_shadow[4][7:3], r_shadow[5][6:5]};
`endif

  assign req_addr    = r_addr;
  assign err_timeout = r_err;
  assign sec         = r_sec;
  assign vl_flag     = r_vl;
  assign min         = r_min;
  assign hour        = r_hour;
  assign day         = r_day;
  assign wday        = r_wday;
  assign mon         = r_mon;
  assign century     = r_cent;
  assign year        = r_year;

endmodule

// File: doc/pcf8563_time_sched.md
Name: pcf8563_time_sched

Overview:
- Scheduler/sequencer on top of the byte-level PCF8563 read interface.
- Periodically, or on demand, issues seven single-register reads (0x02..0x08: seconds..years) and collects the bytes into a shadow buffer.
- Masks the bytes into BCD time fields and publishes a coherent timestamp with a one-cycle valid strobe.
- Sits between the system time consumers (APDAQ timestamping) and the IIC RTC interface, which it owns exclusively.

Parameters:
- POLL_DIV, 100_000_000, clk cycles between automatic polls (must be >= 2).
- BASE_ADDR, 8'h02, first RTC register read (VL_seconds).
- N_REGS, 7, registers per frame (fixed at 7 for field mapping).
- TIMEOUT_CYC, 2_000_000, max clk cycles waiting for req_done per byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enables the poll timer and new frames
- force_rd  in  1  single-cycle pulse; requests an immediate frame
- req_start  out  1  single-cycle pulse; starts one register read downstream
- req_addr  out  8  register address, held stable from req_start until req_done
- req_rdata  in  8  byte returned by the downstream interface, valid when req_done=1
- req_done  in  1  single-cycle pulse; downstream read complete
- sec  out  7  BCD seconds
- min  out  7  BCD minutes
- hour  out  6  BCD hours
- day  out  6  BCD day of month
- wday  out  3  weekday
- mon  out  5  BCD month
- century  out  1  century flag (months register bit 7)
- year  out  8  BCD year
- vl_flag  out  1  VL bit (seconds register bit 7) of the last published frame
- time_valid  out  1  single-cycle strobe when fields update
- busy  out  1  high from frame start to frame end or abort
- err_timeout  out  1  sticky; set on a byte timeout, cleared by the next published frame

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, poll counter 0, pending 0, shadow buffer 0.
- Poll counter:
  - Runs only while en=1 and wraps at POLL_DIV-1.
  - Wrap sets pending. force_rd sets pending regardless of counter.
  - pending is 1 deep: extra ticks or forces while pending or busy coalesce.
  - en=0 clears the counter and pending.
- States:
  - IDLE: if en && pending -> ISSUE; clear pending, idx=0, busy=1.
  - ISSUE: req_addr=BASE_ADDR+idx; req_start=1 for exactly this cycle -> WAIT_DONE; timeout counter=0.
  - WAIT_DONE: on req_done, shadow[idx]=req_rdata -> NEXT. If timeout counter reaches TIMEOUT_CYC-1 without req_done: err_timeout=1, busy=0 -> IDLE, no publish.
  - NEXT: if en=0 -> IDLE, busy=0, no publish. Else if idx==N_REGS-1 -> PUBLISH. Else idx+1 -> ISSUE.
  - PUBLISH: drive outputs from shadow; time_valid=1 this cycle; err_timeout=0; busy=0 -> IDLE.
- Field masks at publish:
  - sec = s[0][6:0], vl_flag = s[0][7]
  - min = s[1][6:0]
  - hour = s[2][5:0]
  - day = s[3][5:0]
  - wday = s[4][2:0]
  - mon = s[5][4:0], century = s[5][7]
  - year = s[6]
- req_done outside WAIT_DONE is ignored.
- en falling mid-byte: the in-flight byte is allowed to complete (never abandon the downstream transfer), then abort in NEXT.
- Latency: req_done of the 7th byte -> time_valid exactly 2 cycles later.
- Published fields hold their value between frames; aborts and timeouts never change them.
- Back-to-back: pending set during busy starts the next frame in the cycle after return to IDLE.

Optional Feature:
- Macro: PCF8563_SEC_RECHECK_EN.
- Defined: after byte 6, re-read register BASE_ADDR as an 8th access.
  - If its [6:0] differs from shadow[0][6:0] (rollover during the frame), discard and restart the frame from idx=0, at most 1 retry.
  - A second mismatch publishes the retry's data.
  - Latency then counts from the 8th req_done.
- Undefined: 7 accesses only, no recheck.

Test Plan:
- Reset with rst_n=0 mid-frame: all outputs 0 immediately (async). After release, no req_start until a tick or force_rd.
- force_rd with a model returning 0x95,0x59,0x23,0x31,0x06,0x92,0x24: req_addr sequence 0x02..0x08; sec=0x15, vl_flag=1, min=0x59, hour=0x23, day=0x31, wday=6, mon=0x12, century=1, year=0x24; one time_valid pulse 2 cycles after the last req_done.
- POLL_DIV=1000, en=1, model done latency 20 cycles: frames start every 1000 cycles. force_rd pulses during busy produce no extra frame beyond one coalesced pending.
- Model withholds req_done on byte 3, TIMEOUT_CYC=500: err_timeout=1 after 500 cycles, busy=0, fields unchanged. Next good frame clears err_timeout.
- en dropped while waiting on byte 2: that byte completes, no further req_start, no time_valid, busy=0.
- With PCF8563_SEC_RECHECK_EN, seconds returned as 0x59 then 0x00 on recheck: frame restarts once and publishes the retry data (sec=0x00).
